// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake, redirect input and the
// instruction/fields presented to decode.
interface fetch_unit_if #(
    parameter int AW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          id_ready;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [AW-1:0] if_pc;
    logic [3:0]    op;
    logic [3:0]    rd;
    logic [3:0]    rs1;
    logic [3:0]    rs2;
    logic [15:0]   imm;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, op, rd, rs1, rs2, imm,
        input  imem_ack, imem_rdata, id_ready, br_taken, br_target
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, op, rd, rs1, rs2, imm,
        output imem_ack, imem_rdata, id_ready, br_taken, br_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request/ack fetch from instruction memory,
// branch redirect (also while a fetch is outstanding) and decode hand-off.
module fetch_unit #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, DISCARD, ISSUE} state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] pc;
    logic [AW-1:0] tgt;
    logic [AW-1:0] ipc;
    logic [31:0]   ir;
    logic          valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH: begin
                if (bus.imem_ack && !bus.br_taken)      state_next = ISSUE;
                else if (!bus.imem_ack && bus.br_taken) state_next = DISCARD;
            end
            DISCARD: if (bus.imem_ack) state_next = FETCH;
            ISSUE:   if (bus.br_taken || bus.id_ready) state_next = FETCH;
            default: state_next = BOOT;
        endcase
    end

    // The address of an outstanding request never moves; a redirect that
    // arrives mid-fetch is parked in tgt until the stale ack is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= RESET_PC;
            tgt <= '0;
            ipc <= '0;
            ir  <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.imem_ack && !bus.br_taken) begin
                        ir  <= bus.imem_rdata;
                        ipc <= pc;
                        pc  <= pc + AW'(4);
                    end else if (bus.imem_ack && bus.br_taken) begin
                        pc <= bus.br_target;
                    end else if (bus.br_taken) begin
                        tgt <= bus.br_target;
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) pc  <= bus.br_taken ? bus.br_target : tgt;
                    else if (bus.br_taken) tgt <= bus.br_target;
                end
                ISSUE: begin
                    if (bus.br_taken) pc <= bus.br_target;
                end
                default: ;
            endcase
        end
    end

    // Fields are forced to zero outside ISSUE since opcode 0 is a real ADD.
    always_comb begin
        valid          = (state == ISSUE);
        bus.imem_req   = (state == FETCH) || (state == DISCARD);
        bus.imem_addr  = pc;
        bus.if_valid   = valid;
        bus.if_instr   = valid ? ir  : 32'd0;
        bus.if_pc      = valid ? ipc : '0;
        bus.op         = bus.if_instr[31:28];
        bus.rd         = bus.if_instr[27:24];
        bus.rs1        = bus.if_instr[23:20];
        bus.rs2        = bus.if_instr[19:16];
        bus.imm        = bus.if_instr[15:0];
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of the
// fetch stage; includes a wrap-around instance with RESET_PC near the top.
module tb_fetch_unit;
    localparam int          AW      = 32;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.AW(AW)) bus ();
    fetch_unit_if #(.AW(AW)) wbus ();

    fetch_unit #(.AW(AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );
    fetch_unit #(.AW(AW), .RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(wbus.master)
    );

    int errorCount = 0;
    int checkCount = 0;

    // Model of the fetch stage: started / holding an instruction / owing a
    // stale response that must be dropped before redirecting.
    bit          mStarted, mHolding, mFlush;
    logic [31:0] mAddr, mRedirect, mInstr, mIpc;
    int          waitLeft;
    int          maxWait, readyPct, brPct;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h0123_ABCD;
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic modelReset();
        mStarted  = 1'b0;
        mHolding  = 1'b0;
        mFlush    = 1'b0;
        mAddr     = 32'h0;
        mRedirect = 32'h0;
        mInstr    = 32'h0;
        mIpc      = 32'h0;
        waitLeft  = $urandom_range(maxWait);
    endtask

    task automatic compareAll();
        logic [31:0] expInstr;
        expInstr = mHolding ? mInstr : 32'h0;
        checkOutput("imem_req",  32'(bus.imem_req), 32'(mStarted && !mHolding));
        checkOutput("imem_addr", bus.imem_addr, mAddr);
        checkOutput("if_valid",  32'(bus.if_valid), 32'(mHolding));
        checkOutput("if_instr",  bus.if_instr, expInstr);
        checkOutput("if_pc",     bus.if_pc, mHolding ? mIpc : 32'h0);
        checkOutput("op",        32'(bus.op),  32'(expInstr[31:28]));
        checkOutput("rd",        32'(bus.rd),  32'(expInstr[27:24]));
        checkOutput("rs1",       32'(bus.rs1), 32'(expInstr[23:20]));
        checkOutput("rs2",       32'(bus.rs2), 32'(expInstr[19:16]));
        checkOutput("imm",       32'(bus.imm), 32'(expInstr[15:0]));
    endtask

    task automatic applyStimulus();
        bit req;
        req = mStarted && !mHolding;
        if (req) bus.imem_ack = (waitLeft == 0);
        else     bus.imem_ack = ($urandom_range(3) == 0);
        bus.imem_rdata = (req && bus.imem_ack) ? memWord(mAddr) : $urandom();
        bus.id_ready   = ($urandom_range(99) < readyPct);
        bus.br_taken   = ($urandom_range(99) < brPct);
        bus.br_target  = ($urandom_range(7) == 0) ? $urandom() : ($urandom() & 32'h0000_0FFC);
    endtask

    task automatic modelUpdate();
        if (!mStarted) begin
            mStarted = 1'b1;
        end else if (mHolding) begin
            if (bus.br_taken) begin
                mAddr    = bus.br_target;
                mHolding = 1'b0;
            end else if (bus.id_ready) begin
                mHolding = 1'b0;
            end
        end else if (bus.imem_ack) begin
            waitLeft = $urandom_range(maxWait);
            if (mFlush) begin
                mAddr  = bus.br_taken ? bus.br_target : mRedirect;
                mFlush = 1'b0;
            end else if (bus.br_taken) begin
                mAddr = bus.br_target;
            end else begin
                mInstr   = bus.imem_rdata;
                mIpc     = mAddr;
                mAddr    = mAddr + 32'd4;
                mHolding = 1'b1;
            end
        end else begin
            if (waitLeft > 0) waitLeft--;
            if (bus.br_taken) begin
                mFlush    = 1'b1;
                mRedirect = bus.br_target;
            end
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            compareAll();
            applyStimulus();
            @(posedge clk);
            if (rst_n) modelUpdate();
            @(negedge clk);
        end
    endtask

    // Drops rst_n between edges and expects reset values before the next edge.
    task automatic asyncReset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        checkOutput({tag, "_req"},   32'(bus.imem_req), 32'd0);
        checkOutput({tag, "_valid"}, 32'(bus.if_valid), 32'd0);
        checkOutput({tag, "_instr"}, bus.if_instr, 32'd0);
        checkOutput({tag, "_pc"},    bus.if_pc, 32'd0);
        checkOutput({tag, "_addr"},  bus.imem_addr, 32'd0);
        checkOutput({tag, "_waddr"}, wbus.imem_addr, WRAP_PC);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wbus.imem_ack   = 1'b1;
        wbus.imem_rdata = 32'h0123_ABCD;
        wbus.id_ready   = 1'b1;
        wbus.br_taken   = 1'b0;
        wbus.br_target  = 32'h0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.id_ready    = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 32'h0;
        maxWait  = 0;
        readyPct = 100;
        brPct    = 0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait memory, decode always ready, no redirects.
        for (int k = 0; k < 6; k++) begin
            compareAll();
            case (k)
                0: begin
                    checkOutput("boot_req", 32'(bus.imem_req), 32'd0);
                    checkOutput("wrap_boot_addr", wbus.imem_addr, WRAP_PC);
                end
                1: begin
                    checkOutput("first_req", 32'(bus.imem_req), 32'd1);
                    checkOutput("first_addr", bus.imem_addr, 32'h0);
                    checkOutput("wrap_first_req", 32'(wbus.imem_req), 32'd1);
                    checkOutput("wrap_first_addr", wbus.imem_addr, WRAP_PC);
                end
                2: begin
                    checkOutput("first_valid", 32'(bus.if_valid), 32'd1);
                    checkOutput("first_op", 32'(bus.op), 32'd0);
                    checkOutput("first_rd", 32'(bus.rd), 32'd1);
                    checkOutput("first_rs1", 32'(bus.rs1), 32'd2);
                    checkOutput("first_rs2", 32'(bus.rs2), 32'd3);
                    checkOutput("first_imm", 32'(bus.imm), 32'h0000_ABCD);
                    checkOutput("first_pc", bus.if_pc, 32'h0);
                    checkOutput("wrap_if_pc", wbus.if_pc, WRAP_PC);
                    checkOutput("wrap_next_pc", wbus.imem_addr, 32'h0);
                end
                3: begin
                    checkOutput("second_addr", bus.imem_addr, 32'h4);
                    checkOutput("wrap_second_req", 32'(wbus.imem_req), 32'd1);
                    checkOutput("wrap_second_addr", wbus.imem_addr, 32'h0);
                end
                5: checkOutput("third_addr", bus.imem_addr, 32'h8);
                default: ;
            endcase
            applyStimulus();
            @(posedge clk);
            modelUpdate();
            @(negedge clk);
        end

        // Heavy back-pressure with wait states, then mixed traffic with redirects.
        maxWait  = 3;
        readyPct = 15;
        brPct    = 0;
        runCycles(150);
        readyPct = 60;
        brPct    = 12;
        runCycles(400);

        begin
            int guard = 0;
            while (!mHolding && guard < 500) begin
                runCycles(1);
                guard++;
            end
            checkOutput("reach_issue", 32'(bus.if_valid), 32'd1);
            asyncReset("rst_issue");
        end

        readyPct = 40;
        brPct    = 25;
        runCycles(300);

        begin
            int guard = 0;
            while (!(mFlush && waitLeft > 0) && guard < 500) begin
                runCycles(1);
                guard++;
            end
            checkOutput("reach_discard", 32'(bus.imem_req && mFlush), 32'd1);
            asyncReset("rst_discard");
        end

        brPct = 35;
        runCycles(400);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
